// File: rtl/cci_mmio_rsp_arbiter_if.sv
// Bundle of the N_REQ responder inputs and the shared c2Tx MMIO read-response
// output. The responder side drives the master modport; the arbiter uses slave.
`timescale 1ns/1ps

interface cci_mmio_rsp_arbiter_if #(
    parameter int N_REQ = 2
);
    // in_valid[i] is a one-cycle strobe: the response is taken at the edge
    // (or counted as dropped). There is no ready; in_almfull[i] is advisory
    // and out_valid has no backpressure.
    logic [N_REQ-1:0]    in_valid;
    logic [N_REQ*9-1:0]  in_tid;
    logic [N_REQ*64-1:0] in_data;
    logic [N_REQ-1:0]    in_almfull;
    logic                out_valid;
    logic [8:0]          out_tid;
    logic [63:0]         out_data;
    logic [N_REQ-1:0]    overflow;
    logic [15:0]         drop_count;
    logic [31:0]         rsp_count;

    modport master (
        output in_valid, in_tid, in_data,
        input  in_almfull, out_valid, out_tid, out_data,
        input  overflow, drop_count, rsp_count
    );

    modport slave (
        input  in_valid, in_tid, in_data,
        output in_almfull, out_valid, out_tid, out_data,
        output overflow, drop_count, rsp_count
    );
endinterface

// File: rtl/cci_mmio_rsp_arbiter.sv
// Buffers each responder's MMIO read responses in a private FIFO and drains
// them round-robin, one per cycle, onto the single registered c2Tx channel.
`timescale 1ns/1ps

module cci_mmio_rsp_arbiter #(
    parameter int N_REQ        = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int ALMFULL_FREE = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cci_mmio_rsp_arbiter_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int EW = 9 + 64;

    logic [EW-1:0]    r_mem [N_REQ][FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr [N_REQ];
    logic [AW-1:0]    r_rd_ptr [N_REQ];
    logic [CW-1:0]    r_count [N_REQ];
    logic [N_REQ-1:0] r_almfull;
    logic [N_REQ-1:0] r_overflow;
    logic [PW-1:0]    r_rr_ptr;
    logic             r_out_valid;
    logic [8:0]       r_out_tid;
    logic [63:0]      r_out_data;
    logic [15:0]      r_drop_count;
    logic [31:0]      r_rsp_count;

    logic [N_REQ-1:0] w_empty;
    logic [N_REQ-1:0] w_full;
    logic [N_REQ-1:0] w_push;
    logic [N_REQ-1:0] w_pop;
    logic [N_REQ-1:0] w_drop;
    logic [CW-1:0]    w_cnt_nxt [N_REQ];
    logic             w_gnt_vld;
    logic [PW-1:0]    w_gnt_idx;
    logic [PW-1:0]    w_rr_nxt;
    logic [EW-1:0]    w_head;
    logic [3:0]       w_drop_sum;
    logic [16:0]      w_drop_tot;

    // Port index visited k steps after the round-robin pointer, modulo N_REQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_empty[i] = (r_count[i] == '0);
            w_full[i]  = (r_count[i] == CW'(FIFO_DEPTH));
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_gnt_vld && !w_empty[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_rr_nxt = (w_gnt_idx == PW'(N_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
    assign w_head   = r_mem[w_gnt_idx][r_rd_ptr[w_gnt_idx]];

    // A full FIFO still accepts a write when it is popped at the same edge.
    always_comb begin
        w_drop_sum = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pop[i]     = w_gnt_vld && (w_gnt_idx == PW'(i));
            w_push[i]    = bus.in_valid[i] && (!w_full[i] || w_pop[i]);
            w_drop[i]    = bus.in_valid[i] && w_full[i] && !w_pop[i];
            w_cnt_nxt[i] = r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            w_drop_sum   = w_drop_sum + 4'(w_drop[i]);
        end
        w_drop_tot = {1'b0, r_drop_count} + 17'(w_drop_sum);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= {bus.in_tid[9*i +: 9], bus.in_data[64*i +: 64]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_almfull  <= '0;
            r_overflow <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
                if (w_drop[i]) r_overflow[i] <= 1'b1;
                r_count[i]   <= w_cnt_nxt[i];
                r_almfull[i] <= ((FIFO_DEPTH - int'(w_cnt_nxt[i])) <= ALMFULL_FREE);
            end
        end
    end

    // Without a grant the data/tid registers hold; only out_valid drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_tid    <= '0;
            r_out_data   <= '0;
            r_drop_count <= '0;
            r_rsp_count  <= '0;
        end else begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                {r_out_tid, r_out_data} <= w_head;
                r_rr_ptr    <= w_rr_nxt;
                r_rsp_count <= r_rsp_count + 32'd1;
            end
            r_drop_count <= w_drop_tot[16] ? 16'hFFFF : w_drop_tot[15:0];
        end
    end

    assign bus.in_almfull = r_almfull;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_tid    = r_out_tid;
    assign bus.out_data   = r_out_data;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
    assign bus.rsp_count  = r_rsp_count;

endmodule

// File: tb/tb_cci_mmio_rsp_arbiter.sv
// Random and directed stimulus for cci_mmio_rsp_arbiter, checked against a
// queue-based reference model and an expected-output scoreboard.
`timescale 1ns/1ps

module tb_cci_mmio_rsp_arbiter;
    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int FREE  = 2;
    localparam int W     = 73;

    logic clk;
    logic reset_n;
    cci_mmio_rsp_arbiter_if #(.N_REQ(N)) bus ();

    cci_mmio_rsp_arbiter #(
        .N_REQ(N), .FIFO_DEPTH(DEPTH), .ALMFULL_FREE(FREE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mq[N][$];
    int            m_rr;
    int            m_drops;
    logic [31:0]   m_rsp;
    logic [N-1:0]  m_ovf;
    int            m_g;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_q.delete();
            m_rr = 0; m_drops = 0; m_rsp = '0; m_ovf = '0;
        end else begin
            m_g = -1;
            for (int k = 0; k < N; k++)
                if (m_g < 0 && mq[(m_rr + k) % N].size() != 0) m_g = (m_rr + k) % N;
            if (m_g >= 0) begin
                exp_q.push_back(mq[m_g].pop_front());
                m_rr  = (m_g + 1) % N;
                m_rsp = m_rsp + 1;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.in_valid[i]) begin
                    if (mq[i].size() < DEPTH) begin
                        mq[i].push_back({bus.in_tid[9*i +: 9], bus.in_data[64*i +: 64]});
                    end else begin
                        m_ovf[i] = 1'b1;
                        if (m_drops < 16'hFFFF) m_drops++;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] exp_e;
    logic [N-1:0] exp_am;

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            if (bus.out_valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("out_tid", 64'(bus.out_tid), 64'(exp_e[72:64]));
                    chk("out_data", bus.out_data, exp_e[63:0]);
                end
            end else begin
                chk("out_missing", 64'd0, 64'(exp_q.size()));
                exp_q.delete();
            end
            for (int i = 0; i < N; i++) exp_am[i] = ((DEPTH - mq[i].size()) <= FREE);
            chk("in_almfull", 64'(bus.in_almfull), 64'(exp_am));
            chk("overflow", 64'(bus.overflow), 64'(m_ovf));
            chk("drop_count", 64'(bus.drop_count), 64'(m_drops));
            chk("rsp_count", 64'(bus.rsp_count), 64'(m_rsp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put(input int port, input logic [8:0] tid, input logic [63:0] data);
        bus.in_valid[port]       = 1'b1;
        bus.in_tid[9*port +: 9]  = tid;
        bus.in_data[64*port +: 64] = data;
    endtask

    task automatic idle(input int n);
        bus.in_valid = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic cycle_mask(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[i]) put(i, 9'($urandom_range(0, 511)), {$urandom, $urandom});
        @(negedge clk);
        bus.in_valid = '0;
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int sent;
    int n0;
    int guard;

    initial begin
        reset_n = 1'b0;
        bus.in_valid = '0;
        bus.in_tid = '0;
        bus.in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_tid", 64'(bus.out_tid), 64'd0);
        chk("rst_almfull", 64'(bus.in_almfull), 64'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // single response: two-cycle latency
        put(0, 9'h005, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        bus.in_valid = '0;
        chk("lat_not_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_tid", 64'(bus.out_tid), 64'h005);
        chk("lat_data", bus.out_data, 64'hDEAD_BEEF);
        chk("lat_rsp_count", 64'(bus.rsp_count), 64'd1);
        idle(3);

        // two ports in the same cycle after reset
        do_reset();
        idle(1);
        put(0, 9'h011, 64'h11);
        put(1, 9'h022, 64'h22);
        @(negedge clk);
        bus.in_valid = '0;
        @(negedge clk);
        chk("pair_first", 64'(bus.out_tid), 64'h011);
        @(negedge clk);
        chk("pair_second", 64'(bus.out_tid), 64'h022);
        chk("pair_second_v", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        chk("pair_done", 64'(bus.out_valid), 64'd0);
        chk("pair_drops", 64'(bus.drop_count), 64'd0);
        idle(2);

        // ports 0 and 1 saturated for 100 cycles
        do_reset();
        idle(1);
        n0 = n_out;
        sent = 0;
        for (int c = 0; c < 100; c++) begin
            put(0, {3'd0, 6'(c)}, {32'h0, 32'(c)});
            put(1, {3'd1, 6'(c)}, {32'h1, 32'(c)});
            sent += 2;
            @(negedge clk);
        end
        idle(12);
        chk("sat2_overflow", 64'(bus.overflow[1:0]), 64'd3);
        chk("sat2_drop_eq", 64'(bus.drop_count), 64'(sent - (n_out - n0)));
        chk("sat2_rsp_eq", 64'(bus.rsp_count), 64'(n_out - n0));

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) cycle_mask(N'($urandom_range(0, (1 << N) - 1)));
            else cycle_mask(N'($urandom_range(0, 1)) << $urandom_range(0, N - 1));
        end
        idle(10);

        // drive every port until the drop counter saturates, then keep dropping
        do_reset();
        idle(1);
        guard = 0;
        while (m_drops < 16'hFFFF && guard < 20000) begin
            cycle_mask('1);
            guard++;
        end
        chk("sat_reached", 64'(guard < 20000), 64'd1);
        repeat (5) cycle_mask('1);
        chk("sat_drop_ffff", 64'(bus.drop_count), 64'hFFFF);
        idle(8);

        // asynchronous reset with entries buffered
        for (int c = 0; c < 3; c++) begin
            put(0, 9'(c), 64'(c));
            put(1, 9'(c + 8), 64'(c + 8));
            put(2, 9'(c + 16), 64'(c + 16));
            @(negedge clk);
        end
        bus.in_valid = '0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_overflow", 64'(bus.overflow), 64'd0);
        chk("arst_drops", 64'(bus.drop_count), 64'd0);
        chk("arst_rsp", 64'(bus.rsp_count), 64'd0);
        chk("arst_almfull", 64'(bus.in_almfull), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(6);
        chk("arst_no_stale", 64'(bus.rsp_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
